// File: rtl/dbus_pair_sequencer_if.sv
// Bus bundle between the memory-stage lanes, the pair sequencer and the single-port dcache.
// master = sequencer view, slave = pipeline/cache environment view.
interface dbus_pair_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]             lreq_valid;
  logic [1:0][ADDR_W-1:0] lreq_addr;
  logic [1:0][1:0]        lreq_size;
  logic [1:0][3:0]        lreq_strobe;
  logic [1:0][31:0]       lreq_data;

  logic                   stall;
  logic                   resp_valid;
  logic [63:0]            resp_data;
  logic                   resp_uncached;

  logic                   oreq_valid;
  logic [ADDR_W-1:0]      oreq_addr;
  logic [1:0]             oreq_size;
  logic [3:0]             oreq_strobe;
  logic [31:0]            oreq_data;
  logic                   oresp_addr_ok;
  logic                   oresp_data_ok;
  logic [31:0]            oresp_data;

  modport master (
    input  lreq_valid, lreq_addr, lreq_size, lreq_strobe, lreq_data,
    input  oresp_addr_ok, oresp_data_ok, oresp_data,
    output stall, resp_valid, resp_data, resp_uncached,
    output oreq_valid, oreq_addr, oreq_size, oreq_strobe, oreq_data
  );

  modport slave (
    output lreq_valid, lreq_addr, lreq_size, lreq_strobe, lreq_data,
    output oresp_addr_ok, oresp_data_ok, oresp_data,
    input  stall, resp_valid, resp_data, resp_uncached,
    input  oreq_valid, oreq_addr, oreq_size, oreq_strobe, oreq_data
  );
endinterface

// File: rtl/dbus_pair_sequencer.sv
// Serializes the two memory-stage lanes (lane 1 first, then lane 0) onto the single-port
// dcache and returns both results as one 64-bit word {lane0, lane1}.
//
// state | meaning
// IDLE  | waiting for any valid lane; latches lane-0 valid and uncached flag
// REQ1  | lane 1 request presented downstream
// WAIT1 | lane 1 accepted, waiting for data
// REQ0  | lane 0 request presented downstream
// WAIT0 | lane 0 accepted, waiting for data
// DONE  | one-cycle result pulse, pipeline released
module dbus_pair_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int UNCACHE_BIT = 29
) (
  input  logic                  clk,
  input  logic                  resetn,
  dbus_pair_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ1, S_WAIT1, S_REQ0, S_WAIT0, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             lane0_q, lane0_d;
  logic             unc_q, unc_d;
  logic [1:0][31:0] buf_q, buf_d;
  logic             stall_c;
  logic             drive;
  logic             lane;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      lane0_q <= 1'b0;
      unc_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      lane0_q <= lane0_d;
      unc_q   <= unc_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane0_d = lane0_q;
    unc_d   = unc_q;
    buf_d   = buf_q;
    stall_c = 1'b1;
    drive   = 1'b0;
    lane    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = |bus.lreq_valid;
        if (|bus.lreq_valid) begin
          lane0_d = bus.lreq_valid[0];
          unc_d   = (bus.lreq_valid[1] & bus.lreq_addr[1][UNCACHE_BIT]) |
                    (bus.lreq_valid[0] & bus.lreq_addr[0][UNCACHE_BIT]);
          buf_d   = '0;
          state_d = bus.lreq_valid[1] ? S_REQ1 : S_REQ0;
        end
      end
      S_REQ1: begin
        drive = 1'b1;
        lane  = 1'b1;
        if (bus.oresp_addr_ok) begin
          if (bus.oresp_data_ok) begin
            buf_d[1] = bus.oresp_data;
            state_d  = lane0_q ? S_REQ0 : S_DONE;
          end else begin
            state_d = S_WAIT1;
          end
        end
      end
      S_WAIT1: begin
        if (bus.oresp_data_ok) begin
          buf_d[1] = bus.oresp_data;
          state_d  = lane0_q ? S_REQ0 : S_DONE;
        end
      end
      S_REQ0: begin
        drive = 1'b1;
        if (bus.oresp_addr_ok) begin
          if (bus.oresp_data_ok) begin
            buf_d[0] = bus.oresp_data;
            state_d  = S_DONE;
          end else begin
            state_d = S_WAIT0;
          end
        end
      end
      S_WAIT0: begin
        if (bus.oresp_data_ok) begin
          buf_d[0] = bus.oresp_data;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Pipeline advances on this edge; the next pair is sampled only from IDLE.
        stall_c = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.oreq_valid  = 1'b0;
    bus.oreq_addr   = '0;
    bus.oreq_size   = '0;
    bus.oreq_strobe = '0;
    bus.oreq_data   = '0;
    if (drive) begin
      bus.oreq_valid  = 1'b1;
      bus.oreq_addr   = bus.lreq_addr[lane];
      bus.oreq_size   = bus.lreq_size[lane];
      bus.oreq_strobe = bus.lreq_strobe[lane];
      bus.oreq_data   = bus.lreq_data[lane];
    end
  end

  // Gated by resetn so stall drops the instant reset is asserted.
  assign bus.stall         = resetn & stall_c;
  assign bus.resp_valid    = (state_q == S_DONE);
  assign bus.resp_data     = {buf_q[0], buf_q[1]};
  assign bus.resp_uncached = unc_q & (state_q == S_DONE);

endmodule

// File: tb/tb_dbus_pair_sequencer.sv
// Directed bench for dbus_pair_sequencer: cycle-stepped scenarios with hand-computed expectations.
module tb_dbus_pair_sequencer;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dbus_pair_sequencer_if #(.ADDR_W(32)) dbus ();

  dbus_pair_sequencer #(.ADDR_W(32), .UNCACHE_BIT(29)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dbus)
  );

  task automatic clear_inputs();
    dbus.lreq_valid    = '0;
    dbus.lreq_addr     = '0;
    dbus.lreq_size     = '0;
    dbus.lreq_strobe   = '0;
    dbus.lreq_data     = '0;
    dbus.oresp_addr_ok = 1'b0;
    dbus.oresp_data_ok = 1'b0;
    dbus.oresp_data    = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    dbus.lreq_valid = 2'b11;
    #3;
    checks++; if (dbus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", dbus.stall); end
    checks++; if (dbus.oreq_valid !== 1'b0) begin failures++; $display("FAIL reset_oreq_valid: got %b expected 0", dbus.oreq_valid); end
    checks++; if ({dbus.oreq_addr, dbus.oreq_size, dbus.oreq_strobe, dbus.oreq_data} !== '0) begin failures++; $display("FAIL reset_oreq_fields: addr %h data %h expected 0", dbus.oreq_addr, dbus.oreq_data); end
    checks++; if (dbus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", dbus.resp_valid); end
    checks++; if (dbus.resp_data !== 64'h0) begin failures++; $display("FAIL reset_resp_data: got %h expected 0", dbus.resp_data); end
    checks++; if (dbus.resp_uncached !== 1'b0) begin failures++; $display("FAIL reset_resp_uncached: got %b expected 0", dbus.resp_uncached); end
    @(negedge clk);
    dbus.lreq_valid = 2'b00;
    resetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_idle_quiet();
    for (int c = 0; c < 3; c++) begin
      dbus.oresp_data_ok = (c == 1);
      dbus.oresp_addr_ok = (c == 1);
      dbus.oresp_data    = 32'hFEEDFACE;
      @(negedge clk);
      checks++; if ({dbus.stall, dbus.oreq_valid, dbus.resp_valid} !== 3'b000) begin failures++; $display("FAIL idle_quiet c%0d: stall/oreq/resp got %b expected 000", c, {dbus.stall, dbus.oreq_valid, dbus.resp_valid}); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_lane1_only();
    dbus.lreq_valid     = 2'b10;
    dbus.lreq_addr[1]   = 32'h8000_0010;
    dbus.lreq_size[1]   = 2'd2;
    dbus.lreq_strobe[1] = 4'h0;
    for (int c = 0; c < 5; c++) begin
      dbus.oresp_addr_ok = (c == 1);
      dbus.oresp_data_ok = (c == 2);
      dbus.oresp_data    = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
      if (c == 4) dbus.lreq_valid = 2'b00;
      @(negedge clk);
      checks++; if (dbus.stall !== (c <= 2)) begin failures++; $display("FAIL l1_stall c%0d: got %b expected %b", c, dbus.stall, (c <= 2)); end
      checks++; if (dbus.resp_valid !== (c == 3)) begin failures++; $display("FAIL l1_resp_valid c%0d: got %b expected %b", c, dbus.resp_valid, (c == 3)); end
      checks++; if (dbus.oreq_valid !== (c == 1)) begin failures++; $display("FAIL l1_oreq_valid c%0d: got %b expected %b", c, dbus.oreq_valid, (c == 1)); end
      if (c == 1) begin
        checks++; if (dbus.oreq_addr !== 32'h8000_0010) begin failures++; $display("FAIL l1_oreq_addr: got %h expected 80000010", dbus.oreq_addr); end
      end
      if (c == 3) begin
        checks++; if (dbus.resp_data !== 64'h0000_0000_DEAD_BEEF) begin failures++; $display("FAIL l1_resp_data: got %h expected 00000000deadbeef", dbus.resp_data); end
        checks++; if (dbus.resp_uncached !== 1'b0) begin failures++; $display("FAIL l1_uncached: got %b expected 0", dbus.resp_uncached); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_both_lanes();
    dbus.lreq_valid   = 2'b11;
    dbus.lreq_addr[1] = 32'h0000_0100;
    dbus.lreq_addr[0] = 32'h0000_0104;
    dbus.lreq_size    = {2'd2, 2'd2};
    for (int c = 0; c < 7; c++) begin
      dbus.oresp_addr_ok = (c == 1) || (c == 3);
      dbus.oresp_data_ok = (c == 2) || (c == 4);
      dbus.oresp_data    = (c == 2) ? 32'h1111_1111 : (c == 4) ? 32'h2222_2222 : 32'h0;
      if (c == 6) dbus.lreq_valid = 2'b00;
      @(negedge clk);
      checks++; if (dbus.stall !== (c <= 4)) begin failures++; $display("FAIL both_stall c%0d: got %b expected %b", c, dbus.stall, (c <= 4)); end
      checks++; if (dbus.oreq_valid !== ((c == 1) || (c == 3))) begin failures++; $display("FAIL both_oreq_valid c%0d: got %b", c, dbus.oreq_valid); end
      checks++; if (dbus.resp_valid !== (c == 5)) begin failures++; $display("FAIL both_resp_valid c%0d: got %b expected %b", c, dbus.resp_valid, (c == 5)); end
      if (c == 1 || c == 3) begin
        checks++; if (dbus.oreq_addr !== ((c == 1) ? 32'h100 : 32'h104)) begin failures++; $display("FAIL both_order c%0d: got %h expected %h", c, dbus.oreq_addr, (c == 1) ? 32'h100 : 32'h104); end
      end
      if (c == 5) begin
        checks++; if (dbus.resp_data !== 64'h2222_2222_1111_1111) begin failures++; $display("FAIL both_resp_data: got %h expected 2222222211111111", dbus.resp_data); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_lane0_store();
    dbus.lreq_valid     = 2'b01;
    dbus.lreq_addr[0]   = 32'h0000_0200;
    dbus.lreq_size[0]   = 2'd2;
    dbus.lreq_strobe[0] = 4'hF;
    dbus.lreq_data[0]   = 32'hCAFE_F00D;
    for (int c = 0; c < 4; c++) begin
      dbus.oresp_addr_ok = (c == 1);
      dbus.oresp_data_ok = (c == 1);
      dbus.oresp_data    = (c == 1) ? 32'h5A5A_5A5A : 32'h0;
      if (c == 3) dbus.lreq_valid = 2'b00;
      @(negedge clk);
      checks++; if (dbus.stall !== (c <= 1)) begin failures++; $display("FAIL st_stall c%0d: got %b expected %b", c, dbus.stall, (c <= 1)); end
      checks++; if (dbus.oreq_valid !== (c == 1)) begin failures++; $display("FAIL st_oreq_valid c%0d: got %b expected %b", c, dbus.oreq_valid, (c == 1)); end
      checks++; if (dbus.resp_valid !== (c == 2)) begin failures++; $display("FAIL st_resp_valid c%0d: got %b expected %b", c, dbus.resp_valid, (c == 2)); end
      if (c == 1) begin
        checks++; if ({dbus.oreq_addr, dbus.oreq_strobe, dbus.oreq_data} !== {32'h200, 4'hF, 32'hCAFE_F00D}) begin failures++; $display("FAIL st_oreq_fields: addr %h strobe %h data %h expected 200 f cafef00d", dbus.oreq_addr, dbus.oreq_strobe, dbus.oreq_data); end
      end
      if (c == 2) begin
        checks++; if (dbus.resp_data !== 64'h5A5A_5A5A_0000_0000) begin failures++; $display("FAIL st_resp_data: got %h expected 5a5a5a5a00000000", dbus.resp_data); end
        checks++; if (dbus.resp_uncached !== 1'b0) begin failures++; $display("FAIL st_uncached: got %b expected 0", dbus.resp_uncached); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_uncached_stalls();
    int pulses = 0;
    logic exp_v;
    dbus.lreq_valid   = 2'b11;
    dbus.lreq_addr[1] = 32'h2000_0040;
    dbus.lreq_addr[0] = 32'h2000_0044;
    for (int c = 0; c < 18; c++) begin
      dbus.oresp_addr_ok = (c == 4) || (c == 11);
      dbus.oresp_data_ok = (c == 7) || (c == 14);
      dbus.oresp_data    = (c == 7) ? 32'hAAAA_0001 : (c == 14) ? 32'hBBBB_0002 : 32'hBAD0_BAD0;
      if (c == 16) dbus.lreq_valid = 2'b00;
      @(negedge clk);
      exp_v = ((c >= 1) && (c <= 4)) || ((c >= 8) && (c <= 11));
      if (dbus.resp_valid === 1'b1) pulses++;
      checks++; if (dbus.oreq_valid !== exp_v) begin failures++; $display("FAIL unc_oreq_valid c%0d: got %b expected %b", c, dbus.oreq_valid, exp_v); end
      checks++; if (dbus.stall !== (c <= 14)) begin failures++; $display("FAIL unc_stall c%0d: got %b expected %b", c, dbus.stall, (c <= 14)); end
      if (exp_v) begin
        checks++; if (dbus.oreq_addr !== ((c <= 4) ? 32'h2000_0040 : 32'h2000_0044)) begin failures++; $display("FAIL unc_order c%0d: got %h", c, dbus.oreq_addr); end
      end
      if (c == 15) begin
        checks++; if ({dbus.resp_valid, dbus.resp_uncached} !== 2'b11) begin failures++; $display("FAIL unc_done: resp_valid/uncached got %b expected 11", {dbus.resp_valid, dbus.resp_uncached}); end
        checks++; if (dbus.resp_data !== 64'hBBBB_0002_AAAA_0001) begin failures++; $display("FAIL unc_resp_data: got %h expected bbbb0002aaaa0001", dbus.resp_data); end
      end
      next_cycle();
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL unc_pulse_count: got %0d expected 1", pulses); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    dbus.lreq_valid   = 2'b11;
    dbus.lreq_addr[1] = 32'h0000_0300;
    dbus.lreq_addr[0] = 32'h0000_0304;
    for (int c = 0; c < 4; c++) begin
      dbus.oresp_addr_ok = (c == 1) || (c == 3);
      dbus.oresp_data_ok = (c == 2);
      dbus.oresp_data    = 32'h3333_3333;
      next_cycle();
    end
    dbus.oresp_addr_ok = 1'b0;
    dbus.oresp_data_ok = 1'b0;
    @(negedge clk);
    checks++; if ({dbus.stall, dbus.oreq_valid} !== 2'b10) begin failures++; $display("FAIL rst_pre_wait0: stall/oreq got %b expected 10", {dbus.stall, dbus.oreq_valid}); end
    #1 resetn = 1'b0;
    #1;
    checks++; if ({dbus.stall, dbus.oreq_valid, dbus.resp_valid} !== 3'b000) begin failures++; $display("FAIL rst_async: stall/oreq/resp got %b expected 000", {dbus.stall, dbus.oreq_valid, dbus.resp_valid}); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    dbus.lreq_valid = 2'b00;
    resetn = 1'b1;
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      dbus.oresp_data_ok = (c == 0);
      dbus.oresp_data    = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++; if ({dbus.stall, dbus.oreq_valid, dbus.resp_valid} !== 3'b000) begin failures++; $display("FAIL rst_late_data_ok c%0d: stall/oreq/resp got %b expected 000", c, {dbus.stall, dbus.oreq_valid, dbus.resp_valid}); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int reqs = 0;
    logic exp_v;
    logic [31:0] exp_a;
    dbus.lreq_valid   = 2'b11;
    dbus.lreq_addr[1] = 32'h0000_0400;
    dbus.lreq_addr[0] = 32'h0000_0404;
    for (int c = 0; c < 9; c++) begin
      dbus.oresp_addr_ok = (c >= 1) && (c <= 7);
      dbus.oresp_data_ok = (c >= 1) && (c <= 7);
      case (c)
        1: dbus.oresp_data = 32'hA1A1_A1A1;
        2: dbus.oresp_data = 32'hA0A0_A0A0;
        5: dbus.oresp_data = 32'hB1B1_B1B1;
        6: dbus.oresp_data = 32'hB0B0_B0B0;
        default: dbus.oresp_data = 32'hFFFF_FFFF;
      endcase
      if (c == 4) begin
        dbus.lreq_addr[1] = 32'h0000_0500;
        dbus.lreq_addr[0] = 32'h0000_0504;
      end
      if (c == 8) dbus.lreq_valid = 2'b00;
      @(negedge clk);
      exp_v = (c == 1) || (c == 2) || (c == 5) || (c == 6);
      exp_a = (c == 1) ? 32'h400 : (c == 2) ? 32'h404 : (c == 5) ? 32'h500 : 32'h504;
      if (dbus.oreq_valid === 1'b1) reqs++;
      checks++; if (dbus.oreq_valid !== exp_v) begin failures++; $display("FAIL b2b_oreq_valid c%0d: got %b expected %b", c, dbus.oreq_valid, exp_v); end
      checks++; if (dbus.resp_valid !== ((c == 3) || (c == 7))) begin failures++; $display("FAIL b2b_resp_valid c%0d: got %b", c, dbus.resp_valid); end
      checks++; if (dbus.stall !== ((c <= 2) || ((c >= 4) && (c <= 6)))) begin failures++; $display("FAIL b2b_stall c%0d: got %b", c, dbus.stall); end
      if (exp_v) begin
        checks++; if (dbus.oreq_addr !== exp_a) begin failures++; $display("FAIL b2b_addr c%0d: got %h expected %h", c, dbus.oreq_addr, exp_a); end
      end
      if (c == 3 || c == 7) begin
        checks++; if (dbus.resp_data !== ((c == 3) ? 64'hA0A0_A0A0_A1A1_A1A1 : 64'hB0B0_B0B0_B1B1_B1B1)) begin failures++; $display("FAIL b2b_resp_data c%0d: got %h", c, dbus.resp_data); end
      end
      next_cycle();
    end
    checks++; if (reqs != 4) begin failures++; $display("FAIL b2b_req_count: got %0d expected 4", reqs); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_idle_quiet();
    test_lane1_only();
    test_both_lanes();
    test_lane0_store();
    test_uncached_stalls();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_pair_sequencer.md
# dbus_pair_sequencer

Serializes the two memory-stage lanes' data-bus requests onto the single-port data cache interface, then returns both load results to the memory stage as one 64-bit word. Sits between the execute/memory pipeline registers and the dcache/uncached bridge. Lane 1 is the older instruction and lane 0 the younger. Lane 1 data occupies bits [31:0] and lane 0 data occupies bits [63:32], matching the memory-stage read-data alignment. The block holds the pipeline stalled until every valid lane has completed.

## Interface
- ADDR_W, 32, address width
- UNCACHE_BIT, 29, address bit that marks an uncached access (reported only; ordering is identical)

- clk  in  1  clock
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- lreq_valid  in  2  per-lane request valid, index = lane
- lreq_addr  in  2×ADDR_W  per-lane address
- lreq_size  in  2×2  per-lane size (0=byte, 1=half, 2=word)
- lreq_strobe  in  2×4  per-lane byte strobe; 0 = load
- lreq_data  in  2×32  per-lane store data
- stall  out  1  hold the memory stage and upstream stages
- resp_valid  out  1  one-cycle pulse; resp_data is valid
- resp_data  out  64  {lane0 data, lane1 data}
- resp_uncached  out  1  some lane in the completed pair was uncached
- oreq_valid, oreq_addr, oreq_size, oreq_strobe, oreq_data  out  1/ADDR_W/2/4/32  single-port cache request
- oresp_addr_ok  in  1  request accepted
- oresp_data_ok  in  1  data returned or write done
- oresp_data  in  32  read data

## Operation
- States: IDLE, REQ1, WAIT1, REQ0, WAIT0, DONE.
- IDLE:
  - If any lreq_valid is set, latch the valid mask and uncached flag. Go to REQ1 if lane 1 is valid, else REQ0.
  - stall is combinationally 1 whenever any lreq_valid is set in IDLE.
- REQn:
  - oreq_* are driven from lane n's inputs. Upstream keeps its inputs stable while stall=1.
  - When oresp_addr_ok arrives: if oresp_data_ok is also set that cycle, capture oresp_data into buffer n and advance. Otherwise go to WAITn.
- WAITn:
  - oreq_valid=0.
  - On oresp_data_ok, capture oresp_data into buffer n.
  - Advance from lane 1 to REQ0 if lane 0 is valid, else to DONE. Advance from lane 0 to DONE.
- DONE:
  - resp_valid=1 and stall=0 for exactly one cycle, then go to IDLE.
  - The pipeline advances on this edge. The next request pair is first sampled in the following IDLE cycle, so the same pair is never reissued.
- Buffers:
  - Buffers of invalid lanes read 0.
  - Stores capture whatever oresp_data returns. Consumers ignore store results.
- Only one transaction is outstanding downstream at any time. oresp_data_ok outside the WAIT/REQ states is ignored.
- Lane order is always lane 1 then lane 0, for cached and uncached accesses and for loads and stores. This preserves program order for aliasing addresses.

## Timing
- Reset values:
  - State IDLE; oreq_valid=0; oreq_* fields 0.
  - resp_valid=0; resp_data=0; resp_uncached=0.
  - stall=0 (stall then follows lreq_valid combinationally).
- Reset asserted mid-operation returns to IDLE immediately. Any outstanding downstream transaction is abandoned; the cache is reset by the same signal.
- Single lane, with addr_ok in the first REQ cycle and data_ok one cycle later:
  - c0 IDLE
  - c1 REQ
  - c2 WAIT capture
  - c3 DONE (resp_valid)
  - Total latency is 4 cycles from the first valid cycle to resp_valid.
- Two lanes under the same timing: resp_valid in c5.
- Each cycle without addr_ok adds one REQ cycle. Each cycle without data_ok adds one WAIT cycle.
- addr_ok and data_ok in the same cycle skips the WAIT state and saves one cycle per lane.
- lreq_valid=0 in IDLE keeps the block in IDLE with stall=0 and no downstream activity.

## Test plan
- Lane 1 only: load at addr 0x8000_0010; addr_ok in c1, data_ok+0xDEADBEEF in c2 -> resp_valid only in c3; resp_data=0x0000_0000_DEAD_BEEF; stall=1 during c0–c2.
- Both lanes: loads at 0x100 and 0x104, data 0x11111111 / 0x22222222 -> oreq_addr 0x100 issued before 0x104; resp_valid in c5; resp_data=0x2222_2222_1111_1111.
- Lane 0 only, store with strobe 0xF; addr_ok and data_ok in the same cycle -> no WAIT state; resp_valid in c2; resp_uncached=0.
- Uncached pair (addr bit 29 set): addr_ok withheld 3 cycles, data_ok withheld 2 cycles -> oreq_valid held stable through the stalls; lane order unchanged; resp_uncached=1; exactly one resp_valid pulse.
- resetn pulled low in WAIT0 -> asynchronously stall=0, oreq_valid=0, resp_valid=0; a late oresp_data_ok after release causes no resp_valid.
- Back-to-back pairs with lreq_valid changing on the DONE edge -> second pair issues starting the cycle after DONE; no duplicate downstream request for the first pair.
